// File: rtl/inv_subword_pkg.sv
// Shared types for the InvSubWord byte sequencer.
// States, word geometry and the latency-tracking tag.
package inv_subword_pkg;

  localparam int NB_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    HOLD
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } tag_t;

  function automatic logic [7:0] get_byte(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lat_tag_pipe.sv
// Shift register of tags matching the S-box latency.
// Async active-low clear drops every in-flight tag.
module lat_tag_pipe
  import inv_subword_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t [DEPTH-1:0] pipe_q;
  tag_t [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/inv_subword_seq.sv
// Word-to-byte sequencer around a shared inverse S-box.
// Feeds MSB first, reassembles by tag, holds result.
module inv_subword_seq
  import inv_subword_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [7:0]  sb_in,
  input  logic [7:0]  sb_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  if (SBOX_LAT < 1 || SBOX_LAT > 4) begin : g_bad_lat
    $error("SBOX_LAT must be in 1..4");
  end

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] res_q, res_d;
  logic [7:0]  sb_in_q, sb_in_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  tag_t        tag_in, tag_out;

  lat_tag_pipe #(
    .DEPTH (SBOX_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    res_d       = res_q;
    sb_in_d     = 8'h00;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    tag_in      = '0;
    if (tag_out.valid) begin
      res_d[{tag_out.idx, 3'b000} +: 8] = sb_out;
    end
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          cnt_d   = 2'd0;
          res_d   = '0;
          sb_in_d = in_data[31:24];
          state_d = FEED;
        end
      end
      FEED: begin
        // 3 - cnt on two bits is ~cnt
        tag_in.valid = 1'b1;
        tag_in.idx   = ~cnt_q;
        if (cnt_q == 2'd3) begin
          state_d = DRAIN;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          sb_in_d = get_byte(word_q, ~cnt_d);
        end
      end
      DRAIN: begin
        if (tag_out.valid && tag_out.idx == 2'd0) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_data_d  = res_d;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      res_q       <= '0;
      sb_in_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      res_q       <= res_d;
      sb_in_q     <= sb_in_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sb_in     = sb_in_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_inv_subword_seq.sv
// Scoreboard bench for inv_subword_seq with LAT=1 and LAT=4.
// Behavioural inverse S-box sits on sb_in/sb_out.
module tb_inv_subword_seq;

  localparam logic [7:0] INV [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,
    8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,
    8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,
    8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,
    8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,
    8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,
    8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,
    8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,
    8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,
    8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,
    8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,
    8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,
    8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,
    8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,
    8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,
    8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,
    8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'hdeadbeef;
  logic [7:0]  sb_in;
  logic [7:0]  sb_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        busy;

  logic        in_valid4 = 1'b0;
  logic        in_ready4;
  logic [31:0] in_data4 = 32'h0;
  logic [7:0]  sb_in4;
  logic [7:0]  sb_out4;
  logic        out_valid4;
  logic        out_ready4 = 1'b1;
  logic [31:0] out_data4;
  logic        busy4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int          hs_q[$];
  int          feed_left = 0;
  logic [31:0] feed_word = '0;
  logic        ov_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_subword_seq #(.SBOX_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .sb_in(sb_in), .sb_out(sb_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  inv_subword_seq #(.SBOX_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4),
    .sb_in(sb_in4), .sb_out(sb_out4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .busy(busy4)
  );

  logic [7:0] s1;
  logic [7:0] s4 [4];
  always @(posedge clk) begin
    s1 <= INV[sb_in];
    s4[0] <= INV[sb_in4];
    for (int k = 1; k < 4; k++) s4[k] <= s4[k-1];
  end
  assign sb_out  = s1;
  assign sb_out4 = s4[3];

  function automatic logic [31:0] isw(input logic [31:0] w);
    return {INV[w[31:24]], INV[w[23:16]],
            INV[w[15:8]], INV[w[7:0]]};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: sb_in sequence, output latency, result scoreboard
  always @(negedge clk) begin
    logic [7:0] esb;
    esb = (feed_left > 0) ? feed_word[8*(feed_left-1) +: 8] : 8'h00;
    if (!rst_n) begin
      esb = 8'h00;
      feed_left = 0;
      hs_q.delete();
    end
    chk("sb_in", {24'h0, sb_in}, {24'h0, esb});
    if (feed_left > 0) feed_left--;
    if (rst_n && in_valid && in_ready) begin
      feed_word = in_data;
      feed_left = 4;
      hs_q.push_back(cyc);
    end
    if (out_valid && !ov_prev) begin
      if (hs_q.size() == 0) chk("latency_nohs", 1, 0);
      else chk("latency", cyc - hs_q.pop_front(), 6);
    end
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", out_data, 32'hx);
      else chk("out_data", out_data, exp_q.pop_front());
    end
  end

  task automatic send(input logic [31:0] d, input bit push);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 200) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    if (push) exp_q.push_back(isw(d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hdeadbeef;
  endtask

  task automatic wait_ov(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_out_timeout", 1, 0);
  endtask

  initial begin
    int t, h1, h2;
    bit ok;
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LAT=1 basic
    send(32'h637c00ff, 1'b1);
    repeat (12) @(posedge clk);
    #1;

    // LAT=4 latency
    in_valid4 = 1'b1;
    in_data4  = 32'h637c00ff;
    @(negedge clk);
    t = cyc;
    chk("l4_ready", {31'h0, in_ready4}, 1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("l4_seen", {31'h0, ok}, 1);
    chk("l4_latency", cyc - t, 9);
    chk("l4_data", out_data4, 32'h0001527d);
    @(negedge clk);
    chk("l4_busy_done", {31'h0, busy4}, 0);
    @(posedge clk);
    #1;

    // Backpressure
    out_ready = 1'b0;
    send(32'h637c00ff, 1'b1);
    wait_ov(ok);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'h01020304;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_data", out_data, 32'h0001527d);
      chk("bp_ready", {31'h0, in_ready}, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    h1 = cyc;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_accept_seen", {31'h0, ok}, 1);
    chk("bp_accept_gap", cyc - h1, 1);
    exp_q.push_back(isw(32'h01020304));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Back-to-back
    send(32'h00000000, 1'b1);
    h1 = cyc;
    send(32'hffffffff, 1'b1);
    h2 = cyc;
    chk("b2b_period", h2 - h1, 7);
    chk("b2b_exp0", isw(32'h0), 32'h52525252);
    repeat (10) @(posedge clk);
    #1;

    // Reset mid-operation
    send(32'h11223344, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_in_ready", {31'h0, in_ready}, 1);
    chk("mid_out_valid", {31'h0, out_valid}, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_sb_in", {24'h0, sb_in}, 0);
    chk("mid_busy", {31'h0, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    send(32'ha5a5c3c3, 1'b1);

    // All 256 byte values
    for (int i = 0; i < 64; i++) begin
      send({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 1'b1);
    end

    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
